// File: rtl/fifo_pkg.sv
// Shared defaults and helpers for the synchronous FIFO family.
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_PTR_WIDTH  = 2;

    localparam int SHOWAHEAD_OFF = 0;
    localparam int SHOWAHEAD_ON  = 1;

    // Occupancy must represent 0..2^ptr_w inclusive.
    function automatic int cnt_width(input int ptr_w);
        return ptr_w + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// 1-write/1-read register-file memory, asynchronous read, no array reset.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_PTR_WIDTH
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_ctl.sv
// Synchronous FIFO controller: wrap-bit pointers, count, thresholds,
// sticky error flags, and show-ahead or registered read output.
module sync_fifo_ctl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PTR_WIDTH  = DEF_PTR_WIDTH,
    parameter int SHOWAHEAD  = SHOWAHEAD_ON,
    parameter int AF_LEVEL   = (1 << PTR_WIDTH) - 1,
    parameter int AE_LEVEL   = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clr,
    input  logic [DATA_WIDTH-1:0]           din,
    input  logic                            push,
    input  logic                            pop,
    output logic [DATA_WIDTH-1:0]           dout,
    output logic                            dout_valid,
    output logic [cnt_width(PTR_WIDTH)-1:0] count,
    output logic                            full,
    output logic                            empty,
    output logic                            almost_full,
    output logic                            almost_empty,
    output logic                            overflow,
    output logic                            underflow
);

    localparam int CW = cnt_width(PTR_WIDTH);
    localparam logic [CW-1:0]      AF_L    = CW'(AF_LEVEL);
    localparam logic [CW-1:0]      AE_L    = CW'(AE_LEVEL);
    localparam logic [CW-1:0]      CNT_ONE = CW'(1);
    localparam logic [PTR_WIDTH:0] PTR_ONE = (PTR_WIDTH+1)'(1);

    logic [PTR_WIDTH:0]    r_wr_ptr;
    logic [PTR_WIDTH:0]    r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop_ok;
    logic                  w_push_ok;
    logic                  w_we;
    logic [DATA_WIDTH-1:0] w_rdata;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_WIDTH-1:0] == r_rd_ptr[PTR_WIDTH-1:0])
                  && (r_wr_ptr[PTR_WIDTH] != r_rd_ptr[PTR_WIDTH]);

    assign w_pop_ok  = pop && !w_empty;
    assign w_push_ok = push && (!w_full || w_pop_ok);
    assign w_we      = w_push_ok && !clr;

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (PTR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr[PTR_WIDTH-1:0]),
        .i_wdata (din),
        .i_raddr (r_rd_ptr[PTR_WIDTH-1:0]),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            unique case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clr) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (push && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
            if (pop && !w_pop_ok) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign count        = r_count;
    assign empty        = w_empty;
    assign full         = w_full;
    assign almost_full  = (r_count >= AF_L);
    assign almost_empty = (r_count <= AE_L);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    if (SHOWAHEAD == SHOWAHEAD_ON) begin : g_showahead
        assign dout       = w_empty ? '0 : w_rdata;
        assign dout_valid = !w_empty;
    end else begin : g_registered
        logic [DATA_WIDTH-1:0] r_dout;
        logic                  r_dout_valid;

        // dout holds its last word; flush only drops the valid pulse.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_dout       <= '0;
                r_dout_valid <= 1'b0;
            end else if (clr) begin
                r_dout_valid <= 1'b0;
            end else begin
                r_dout_valid <= w_pop_ok;
                if (w_pop_ok) begin
                    r_dout <= w_rdata;
                end
            end
        end

        assign dout       = r_dout;
        assign dout_valid = r_dout_valid;
    end

endmodule

// File: tb/tb_sync_fifo_ctl.sv
// Directed bench for sync_fifo_ctl, show-ahead and registered instances.
module tb_sync_fifo_ctl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;

    logic [15:0] sa_din;
    logic        sa_push, sa_pop;
    logic [15:0] sa_dout;
    logic        sa_dv;
    logic [2:0]  sa_count;
    logic        sa_full, sa_empty, sa_af, sa_ae, sa_ov, sa_un;

    logic [15:0] rg_din;
    logic        rg_push, rg_pop;
    logic [15:0] rg_dout;
    logic        rg_dv;
    logic [2:0]  rg_count;
    logic        rg_full, rg_empty, rg_af, rg_ae, rg_ov, rg_un;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sync_fifo_ctl #(
        .DATA_WIDTH (16),
        .PTR_WIDTH  (2),
        .SHOWAHEAD  (1)
    ) u_sa (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .din          (sa_din),
        .push         (sa_push),
        .pop          (sa_pop),
        .dout         (sa_dout),
        .dout_valid   (sa_dv),
        .count        (sa_count),
        .full         (sa_full),
        .empty        (sa_empty),
        .almost_full  (sa_af),
        .almost_empty (sa_ae),
        .overflow     (sa_ov),
        .underflow    (sa_un)
    );

    sync_fifo_ctl #(
        .DATA_WIDTH (16),
        .PTR_WIDTH  (2),
        .SHOWAHEAD  (0)
    ) u_rg (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .din          (rg_din),
        .push         (rg_push),
        .pop          (rg_pop),
        .dout         (rg_dout),
        .dout_valid   (rg_dv),
        .count        (rg_count),
        .full         (rg_full),
        .empty        (rg_empty),
        .almost_full  (rg_af),
        .almost_empty (rg_ae),
        .overflow     (rg_ov),
        .underflow    (rg_un)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0;
        sa_din = '0; sa_push = 1'b0; sa_pop = 1'b0;
        rg_din = '0; rg_push = 1'b0; rg_pop = 1'b0;
        #12;
        checks++; if ({sa_count, sa_empty, sa_full, sa_ae, sa_af} !== 7'b000_1010) begin
            errors++; $display("FAIL reset_sa_status: got cnt=%0d e=%b f=%b ae=%b af=%b exp 0 1 0 1 0",
                sa_count, sa_empty, sa_full, sa_ae, sa_af);
        end
        checks++; if ({sa_ov, sa_un, sa_dv, sa_dout} !== 19'h0) begin
            errors++; $display("FAIL reset_sa_out: got ov=%b un=%b dv=%b dout=%h exp 0 0 0 0000",
                sa_ov, sa_un, sa_dv, sa_dout);
        end
        checks++; if ({rg_count, rg_empty, rg_dv, rg_dout} !== {3'd0, 1'b1, 1'b0, 16'h0}) begin
            errors++; $display("FAIL reset_rg: got cnt=%0d e=%b dv=%b dout=%h exp 0 1 0 0000",
                rg_count, rg_empty, rg_dv, rg_dout);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fill();
        sa_push = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            sa_din = 16'(i);
            tick();
            checks++; if (sa_count !== 3'(i)) begin
                errors++; $display("FAIL fill_count[%0d]: got %0d exp %0d", i, sa_count, i);
            end
            checks++; if (sa_full !== (i == 4) || sa_af !== (i >= 3) || sa_ae !== (i <= 1)) begin
                errors++; $display("FAIL fill_flags[%0d]: got f=%b af=%b ae=%b exp %b %b %b",
                    i, sa_full, sa_af, sa_ae, i == 4, i >= 3, i <= 1);
            end
            checks++; if (sa_dout !== 16'h0001 || sa_dv !== 1'b1 || sa_empty !== 1'b0) begin
                errors++; $display("FAIL fill_head[%0d]: got dout=%h dv=%b e=%b exp 0001 1 0",
                    i, sa_dout, sa_dv, sa_empty);
            end
        end
        sa_din = 16'h0005;
        tick();
        sa_push = 1'b0;
        checks++; if (sa_count !== 3'd4 || sa_ov !== 1'b1 || sa_un !== 1'b0) begin
            errors++; $display("FAIL fill_overflow: got cnt=%0d ov=%b un=%b exp 4 1 0",
                sa_count, sa_ov, sa_un);
        end
    endtask

    task automatic test_drain();
        sa_pop = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            checks++; if (sa_dout !== 16'(i) || sa_dv !== 1'b1) begin
                errors++; $display("FAIL drain_data[%0d]: got %h dv=%b exp %h 1", i, sa_dout, sa_dv, 16'(i));
            end
            tick();
        end
        sa_pop = 1'b0;
        checks++; if ({sa_empty, sa_count, sa_dv, sa_dout, sa_un} !== {1'b1, 3'd0, 1'b0, 16'h0, 1'b0}) begin
            errors++; $display("FAIL drain_empty: got e=%b cnt=%0d dv=%b dout=%h un=%b exp 1 0 0 0000 0",
                sa_empty, sa_count, sa_dv, sa_dout, sa_un);
        end
        sa_pop = 1'b1;
        tick();
        sa_pop = 1'b0;
        checks++; if (sa_un !== 1'b1 || sa_ov !== 1'b1 || sa_count !== 3'd0) begin
            errors++; $display("FAIL drain_underflow: got un=%b ov=%b cnt=%0d exp 1 1 0", sa_un, sa_ov, sa_count);
        end
    endtask

    task automatic test_clr_push();
        sa_push = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sa_din = 16'h0031 + 16'(i);
            tick();
        end
        checks++; if (sa_count !== 3'd3) begin
            errors++; $display("FAIL clr_pre_count: got %0d exp 3", sa_count);
        end
        sa_din = 16'h0034;
        clr = 1'b1;
        tick();
        clr = 1'b0; sa_push = 1'b0;
        checks++; if ({sa_count, sa_empty, sa_af, sa_ae, sa_ov, sa_un, sa_dv} !== {3'd0, 6'b101000}) begin
            errors++; $display("FAIL clr_state: got cnt=%0d e=%b af=%b ae=%b ov=%b un=%b dv=%b exp 0 1 0 1 0 0 0",
                sa_count, sa_empty, sa_af, sa_ae, sa_ov, sa_un, sa_dv);
        end
    endtask

    task automatic test_empty_simul();
        sa_din = 16'h0040; sa_push = 1'b1; sa_pop = 1'b1;
        tick();
        sa_push = 1'b0; sa_pop = 1'b0;
        checks++; if (sa_count !== 3'd1 || sa_un !== 1'b1 || sa_ov !== 1'b0 || sa_dout !== 16'h0040) begin
            errors++; $display("FAIL empty_simul: got cnt=%0d un=%b ov=%b dout=%h exp 1 1 0 0040",
                sa_count, sa_un, sa_ov, sa_dout);
        end
        sa_pop = 1'b1;
        tick();
        sa_pop = 1'b0; clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++; if (sa_empty !== 1'b1 || sa_un !== 1'b0) begin
            errors++; $display("FAIL empty_simul_clr: got e=%b un=%b exp 1 0", sa_empty, sa_un);
        end
    endtask

    task automatic test_full_simul();
        logic [15:0] exp_q [4];
        exp_q[0] = 16'h0021; exp_q[1] = 16'h0022;
        exp_q[2] = 16'h0023; exp_q[3] = 16'h0010;
        sa_push = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sa_din = 16'h0020 + 16'(i);
            tick();
        end
        sa_din = 16'h0010; sa_pop = 1'b1;
        checks++; if (sa_full !== 1'b1 || sa_dout !== 16'h0020) begin
            errors++; $display("FAIL full_simul_pre: got f=%b dout=%h exp 1 0020", sa_full, sa_dout);
        end
        tick();
        sa_push = 1'b0;
        checks++; if (sa_count !== 3'd4 || sa_ov !== 1'b0 || sa_full !== 1'b1) begin
            errors++; $display("FAIL full_simul_cnt: got cnt=%0d ov=%b f=%b exp 4 0 1", sa_count, sa_ov, sa_full);
        end
        for (int i = 0; i < 4; i++) begin
            checks++; if (sa_dout !== exp_q[i]) begin
                errors++; $display("FAIL full_simul_order[%0d]: got %h exp %h", i, sa_dout, exp_q[i]);
            end
            tick();
        end
        sa_pop = 1'b0;
        checks++; if (sa_empty !== 1'b1 || sa_un !== 1'b0) begin
            errors++; $display("FAIL full_simul_end: got e=%b un=%b exp 1 0", sa_empty, sa_un);
        end
    endtask

    task automatic test_wrap();
        int bad = 0;
        sa_din = 16'h0100; sa_push = 1'b1;
        tick();
        sa_pop = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sa_din = 16'h0101 + 16'(i);
            if (sa_dout !== 16'h0100 + 16'(i)) begin
                bad++; $display("wrap data[%0d]: got %h exp %h", i, sa_dout, 16'h0100 + 16'(i));
            end
            tick();
            if (sa_count !== 3'd1 || sa_full !== 1'b0) begin
                bad++; $display("wrap status[%0d]: got cnt=%0d f=%b exp 1 0", i, sa_count, sa_full);
            end
        end
        sa_push = 1'b0;
        checks++; if (bad != 0) begin
            errors++; $display("FAIL wrap_stream: got %0d bad samples exp 0", bad);
        end
        checks++; if (sa_dout !== 16'h010a) begin
            errors++; $display("FAIL wrap_last: got %h exp 010a", sa_dout);
        end
        tick();
        sa_pop = 1'b0;
        checks++; if ({sa_empty, sa_ov, sa_un} !== 3'b100) begin
            errors++; $display("FAIL wrap_end: got e=%b ov=%b un=%b exp 1 0 0", sa_empty, sa_ov, sa_un);
        end
    endtask

    task automatic test_registered();
        rg_din = 16'ha5a5; rg_push = 1'b1;
        tick();
        rg_push = 1'b0;
        checks++; if (rg_count !== 3'd1 || rg_dv !== 1'b0 || rg_dout !== 16'h0) begin
            errors++; $display("FAIL reg_push: got cnt=%0d dv=%b dout=%h exp 1 0 0000", rg_count, rg_dv, rg_dout);
        end
        rg_pop = 1'b1;
        tick();
        rg_pop = 1'b0;
        checks++; if (rg_dout !== 16'ha5a5 || rg_dv !== 1'b1 || rg_count !== 3'd0) begin
            errors++; $display("FAIL reg_pop: got dout=%h dv=%b cnt=%0d exp a5a5 1 0", rg_dout, rg_dv, rg_count);
        end
        tick();
        checks++; if (rg_dout !== 16'ha5a5 || rg_dv !== 1'b0) begin
            errors++; $display("FAIL reg_hold: got dout=%h dv=%b exp a5a5 0", rg_dout, rg_dv);
        end
        rg_push = 1'b1;
        rg_din = 16'h0001; tick();
        rg_din = 16'h0002; tick();
        rg_push = 1'b0; rg_pop = 1'b1;
        tick();
        checks++; if (rg_dout !== 16'h0001 || rg_dv !== 1'b1) begin
            errors++; $display("FAIL reg_b2b_0: got dout=%h dv=%b exp 0001 1", rg_dout, rg_dv);
        end
        tick();
        checks++; if (rg_dout !== 16'h0002 || rg_dv !== 1'b1) begin
            errors++; $display("FAIL reg_b2b_1: got dout=%h dv=%b exp 0002 1", rg_dout, rg_dv);
        end
        tick();
        rg_pop = 1'b0;
        checks++; if (rg_dout !== 16'h0002 || rg_dv !== 1'b0 || rg_un !== 1'b1) begin
            errors++; $display("FAIL reg_underflow: got dout=%h dv=%b un=%b exp 0002 0 1", rg_dout, rg_dv, rg_un);
        end
    endtask

    task automatic test_async_reset();
        sa_push = 1'b1;
        sa_din = 16'h0055; tick();
        sa_din = 16'h0066;
        rg_din = 16'h0077; rg_push = 1'b1;
        tick();
        rg_push = 1'b0; rg_pop = 1'b1;
        tick();
        rg_pop = 1'b0;
        checks++; if (sa_count !== 3'd3 || rg_dv !== 1'b1 || rg_dout !== 16'h0077) begin
            errors++; $display("FAIL arst_pre: got sa_cnt=%0d rg_dv=%b rg_dout=%h exp 3 1 0077",
                sa_count, rg_dv, rg_dout);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({sa_count, sa_empty, sa_full, sa_af, sa_ae, sa_dv, sa_dout} !== {3'd0, 5'b10010, 16'h0}) begin
            errors++; $display("FAIL arst_sa: got cnt=%0d e=%b f=%b af=%b ae=%b dv=%b dout=%h exp 0 1 0 0 1 0 0000",
                sa_count, sa_empty, sa_full, sa_af, sa_ae, sa_dv, sa_dout);
        end
        checks++; if ({rg_dv, rg_dout, rg_un, rg_count} !== {1'b0, 16'h0, 1'b0, 3'd0}) begin
            errors++; $display("FAIL arst_rg: got dv=%b dout=%h un=%b cnt=%0d exp 0 0000 0 0",
                rg_dv, rg_dout, rg_un, rg_count);
        end
        sa_push = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        checks++; if (sa_empty !== 1'b1 || sa_ov !== 1'b0) begin
            errors++; $display("FAIL arst_post: got e=%b ov=%b exp 1 0", sa_empty, sa_ov);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_clr_push();
        test_empty_simul();
        test_full_simul();
        test_wrap();
        test_registered();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sync_fifo_ctl.md
# sync_fifo_ctl

Parametrised synchronous FIFO with wrap-bit pointers, occupancy count, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow flags. A build-time mode selects either show-ahead (first-word-fall-through) or registered-read output. It is the general-purpose buffering element between pipeline stages and peripherals in the core, and replaces the fixed-behaviour FIFO.

## Interface
- `DATA_WIDTH`, 16: width of each word.
- `PTR_WIDTH`, 2: address width; depth = 2^PTR_WIDTH.
- `SHOWAHEAD`, 1: 1 = head word always presented on `dout`; 0 = registered read, data one cycle after `pop`.
- `AF_LEVEL`, 2^PTR_WIDTH-1: `almost_full` asserts when count >= AF_LEVEL.
- `AE_LEVEL`, 1: `almost_empty` asserts when count <= AE_LEVEL.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `clr` in 1: synchronous flush; empties FIFO and clears sticky flags.
- `din` in DATA_WIDTH: write data.
- `push` in 1: write request.
- `pop` in 1: read request.
- `dout` out DATA_WIDTH: read data.
- `dout_valid` out 1: `dout` holds a valid word.
- `count` out PTR_WIDTH+1: occupancy, 0..2^PTR_WIDTH.
- `full`, `empty` out 1: occupancy flags.
- `almost_full`, `almost_empty` out 1: threshold flags.
- `overflow`, `underflow` out 1: sticky error flags.

## Operation
- Pointers are PTR_WIDTH+1 bits wide. The MSB is the wrap bit.
  - empty = pointers equal.
  - full = low bits equal and MSBs differ.
- `count` is a registered value, updated by +1, -1, or 0 per cycle. It never leaves 0..2^PTR_WIDTH.
- Pop is accepted when `pop && !empty`.
- Push is accepted when `push && (!full || pop_accepted)`. With push and pop together while full, both succeed and count is unchanged.
- Push and pop together while empty: pop is rejected, push is accepted, count becomes 1, and `underflow` is set.
- Rejected push sets `overflow`. Rejected pop sets `underflow`. Both flags stay set until `rst_n` or `clr`.
- `clr` has priority over push and pop in the same cycle. It zeroes pointers, count, `dout_valid` and both sticky flags. Memory contents are left untouched.
- Show-ahead mode:
  - `dout` = mem[rd_ptr] when !empty, otherwise 0.
  - `dout_valid` = !empty.
  - An accepted pop advances to the next word.
- Registered mode:
  - An accepted pop loads mem[rd_ptr] into the `dout` register.
  - `dout_valid` pulses high for the following cycle.
  - `dout` holds its value until the next accepted pop.
- Memory is write-only on accepted push. No read-side clearing of entries.
- Pointer increment wraps modulo 2^(PTR_WIDTH+1) with no special-case logic.

## Timing
- Reset values:
  - pointers 0, `count` 0.
  - `empty` 1, `full` 0, `almost_empty` 1 (since AE_LEVEL >= 0), `almost_full` 0.
  - `overflow` 0, `underflow` 0.
  - `dout` 0, `dout_valid` 0.
- Reset may assert mid-transfer. All state above returns to reset values immediately, without waiting for a clock edge. Any in-flight `dout_valid` pulse is dropped.
- Push accepted at edge N:
  - `count`, `empty` and `almost_*` update after edge N.
  - Show-ahead: the word is visible on `dout` in cycle N+1.
- Registered mode: pop accepted at edge N gives `dout`/`dout_valid` valid in cycle N+1.
- All status outputs are registered or derived only from registered pointers/count. No combinational path from `push`/`pop` to any flag.
- Back-to-back push or pop every cycle gives full throughput: one word per cycle each direction.

## Structure
- Shared package/include `fifo_pkg` holds:
  - default widths;
  - the SHOWAHEAD mode constants;
  - the count-width function (PTR_WIDTH+1).
- One sub-module: `fifo_ram`, a 1-write/1-read register-file memory with asynchronous read, no reset on the array.
- Pointer logic, count, flags and the output stage stay in `sync_fifo_ctl`.

## Test plan
- Reset then fill: DATA_WIDTH=16, PTR_WIDTH=2. Push 0x0001..0x0004 -> `count`=4, `full`=1, `almost_full`=1 from count 3. A 5th push leaves `count`=4 and sets `overflow`=1.
- Drain in show-ahead: after the fill, pop 4 cycles -> `dout` = 0x0001, 0x0002, 0x0003, 0x0004 in order. `empty`=1 after the last pop. A further pop sets `underflow`.
- Registered mode (SHOWAHEAD=0): push 0xA5A5 then pop -> `dout`=0xA5A5 with a one-cycle `dout_valid` pulse. `dout` holds 0xA5A5 afterward.
- Simultaneous push and pop at full: push 0x0010 together with pop -> `count` stays 4, no `overflow`, and 0x0010 is read out after the three remaining older words.
- Wrap-around: 10 interleaved push/pop pairs of an incrementing pattern -> data is in order, the pointer wrap bit toggles, and `full` never falsely asserts.
- Flush and async reset: assert `clr` together with push at count 3 -> `count`=0, flags cleared. Then drop `rst_n` mid-cycle -> all outputs go to reset values before the next edge.
